// File: rtl/axi_pkg.sv
// AXI shared types and helpers: transaction context, per-beat response context,
// burst/resp encodings, beat-sequencer state and the next-beat address function.
// Latency: n/a (package). Backpressure: n/a.
package axi_pkg;

  localparam int AW           = 32;
  localparam int ID_W         = 4;
  localparam int USER_W       = 4;
  localparam int AXI_4K_SHIFT = 12;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic {
    AXI_SEQ_IDLE  = 1'b0,
    AXI_SEQ_BURST = 1'b1
  } axi_seq_state_e;

  // Captured AR/AW transaction context.
  typedef struct packed {
    logic [AW-1:0]     addr;
    axi_burst_e        burst;
    logic [2:0]        size;
    logic [7:0]        len;
    logic [USER_W-1:0] user;
    logic [ID_W-1:0]   id;
    logic              lock;
  } axi_ctx_t;

  // Per-beat response context handed to the access stage.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [USER_W-1:0] user;
    axi_resp_e         resp;
    logic              last;
  } xfer_ctx_t;

  // Mask of the address bits below the beat size.
  function automatic logic [AW-1:0] axi_size_mask(input logic [2:0] size);
    return (AW'(1) << size) - AW'(1);
  endfunction

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic axi_wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Address of the beat following 'addr'. For WRAP the boundary is derived
  // from the current address, which always stays inside the original
  // container, so it matches the boundary of the first beat.
  function automatic logic [AW-1:0] axi_next_addr(input logic [AW-1:0] addr,
                                                  input axi_burst_e    burst,
                                                  input logic [2:0]    size,
                                                  input logic [7:0]    len);
    logic [AW-1:0] bytes;
    logic [AW-1:0] cont_mask;
    logic [AW-1:0] result;
    bytes     = AW'(1) << size;
    cont_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      AXI_BURST_INCR: result = (addr & ~axi_size_mask(size)) + bytes;
      AXI_BURST_WRAP: result = (addr & ~cont_mask) | ((addr + bytes) & cont_mask);
      default:        result = addr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axi_burst_chk.sv
// Burst legality check: maps an AXI address context to OKAY or SLVERR.
// Latency: combinational. Backpressure: none (pure function of i_ctx).
// Ports: i_ctx (captured context), o_resp (response for every beat).
// Optional: AXI_SEQ_4K_CHECK_EN adds the INCR 4KB-crossing check.
module axi_burst_chk
  import axi_pkg::*;
#(
  parameter int DW = 32
) (
  input  axi_ctx_t  i_ctx,
  output axi_resp_e o_resp
);

  localparam int MAX_SIZE = $clog2(DW / 8);

  logic w_rsvd;
  logic w_size_bad;
  logic w_wrap_bad;
  logic w_4k_bad;
  logic w_unused;

  assign w_rsvd     = (i_ctx.burst == AXI_BURST_RSVD);
  assign w_size_bad = (i_ctx.size > 3'(MAX_SIZE));
  assign w_wrap_bad = (i_ctx.burst == AXI_BURST_WRAP) &&
                      (!axi_wrap_len_ok(i_ctx.len) ||
                       (|(i_ctx.addr & axi_size_mask(i_ctx.size))));

`ifdef AXI_SEQ_4K_CHECK_EN
  // Last beat address of an INCR burst; a differing page number means the
  // burst straddles a 4KB boundary.
  logic [AW-1:0] w_end_addr;
  assign w_end_addr = (i_ctx.addr & ~axi_size_mask(i_ctx.size)) +
                      (AW'(i_ctx.len) << i_ctx.size);
  assign w_4k_bad   = (i_ctx.burst == AXI_BURST_INCR) &&
                      (i_ctx.addr[AW-1:AXI_4K_SHIFT] != w_end_addr[AW-1:AXI_4K_SHIFT]);
`else
  assign w_4k_bad   = 1'b0;
`endif

  assign o_resp = (w_rsvd || w_size_bad || w_wrap_bad || w_4k_bad) ?
                  AXI_RESP_SLVERR : AXI_RESP_OKAY;

  // Identity/lock fields do not affect legality.
  assign w_unused = ^{i_ctx.user, i_ctx.id, i_ctx.lock};

endmodule

// File: rtl/axi_beat_addr_seq.sv
// Beat address sequencer: expands one AXI address context into per-beat
// address, beat index and response context (FIXED/INCR/WRAP, SLVERR on illegal).
// Latency: first beat valid 1 cycle after accept; one idle cycle between bursts.
// Backpressure: s_ready only in IDLE; beat outputs held stable while m_ready=0.
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_ctx context input;
//        m_valid/m_ready, m_addr, m_beat, m_xfer per-beat output.
// Optional: AXI_SEQ_4K_CHECK_EN (in axi_burst_chk) flags INCR 4KB crossings.
module axi_beat_addr_seq
  import axi_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = axi_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  axi_ctx_t      s_ctx,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_beat,
  output xfer_ctx_t     m_xfer
);

  axi_seq_state_e    r_state;
  axi_seq_state_e    w_state_nxt;

  // Burst context held for the duration of the burst.
  axi_burst_e        r_burst;
  logic [2:0]        r_size;
  logic [7:0]        r_len;
  logic [ID_W-1:0]   r_id;
  logic [USER_W-1:0] r_user;
  axi_resp_e         r_resp;
  logic [AW-1:0]     r_addr;
  logic [7:0]        r_beat;

  axi_resp_e         w_resp;
  axi_burst_e        w_eff_burst;
  logic              w_accept;
  logic              w_advance;
  logic              w_last;
  logic              w_unused;

  axi_burst_chk #(
    .DW (DW)
  ) u_burst_chk (
    .i_ctx  (s_ctx),
    .o_resp (w_resp)
  );

  // Sequence actually walked: reserved bursts stay on the start address,
  // illegal WRAPs (bad length or misaligned) walk as INCR.
  always_comb begin
    w_eff_burst = s_ctx.burst;
    case (s_ctx.burst)
      AXI_BURST_RSVD: w_eff_burst = AXI_BURST_FIXED;
      AXI_BURST_WRAP: begin
        if (!axi_wrap_len_ok(s_ctx.len) ||
            (|(s_ctx.addr & axi_size_mask(s_ctx.size)))) begin
          w_eff_burst = AXI_BURST_INCR;
        end
      end
      default: w_eff_burst = s_ctx.burst;
    endcase
  end

  assign w_last = (r_beat == r_len);

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AXI_SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      AXI_SEQ_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = AXI_SEQ_BURST;
        end
      end
      AXI_SEQ_BURST: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (w_last) begin
            w_state_nxt = AXI_SEQ_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = AXI_SEQ_IDLE;
    endcase
  end

  // Context, address and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= AXI_BURST_FIXED;
      r_size  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_user  <= '0;
      r_resp  <= AXI_RESP_OKAY;
      r_addr  <= '0;
      r_beat  <= '0;
    end else if (w_accept) begin
      r_burst <= w_eff_burst;
      r_size  <= s_ctx.size;
      r_len   <= s_ctx.len;
      r_id    <= s_ctx.id;
      r_user  <= s_ctx.user;
      r_resp  <= w_resp;
      r_addr  <= s_ctx.addr;
      r_beat  <= '0;
    end else if (w_advance) begin
      r_addr  <= axi_next_addr(r_addr, r_burst, r_size, r_len);
      r_beat  <= r_beat + 8'd1;
    end
  end

  assign m_addr = r_addr;
  assign m_beat = r_beat;

  // Response context is only meaningful with a valid beat; zero otherwise so
  // that IDLE (and reset) presents an all-zero m_xfer.
  always_comb begin
    m_xfer = '0;
    if (m_valid) begin
      m_xfer.id   = r_id;
      m_xfer.user = r_user;
      m_xfer.resp = r_resp;
      m_xfer.last = w_last;
    end
  end

  // Lock is consumed by the exclusive monitor, not here.
  assign w_unused = s_ctx.lock;

endmodule

// File: tb/tb_axi_beat_addr_seq.sv
module tb_axi_beat_addr_seq;
  import axi_pkg::*;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  axi_ctx_t      s_ctx   = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_beat;
  xfer_ctx_t     m_xfer;

  axi_beat_addr_seq #(.DW(32), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_ctx   (s_ctx),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_beat  (m_beat),
    .m_xfer  (m_xfer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [7:0]        beat;
    logic [ID_W-1:0]   id;
    logic [USER_W-1:0] user;
    logic [1:0]        resp;
    logic              last;
  } exp_t;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic stall_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [7:0] beat,
                      input logic [3:0] id, input logic [3:0] user,
                      input logic [1:0] resp, input logic last);
    exp_t e;
    e.addr = addr; e.beat = beat; e.id = id; e.user = user; e.resp = resp; e.last = last;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1.
  task automatic send(input logic [AW-1:0] addr, input axi_burst_e burst,
                      input logic [2:0] size, input logic [7:0] len,
                      input logic [3:0] id, input logic [3:0] user);
    int guard = 0;
    while (!s_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: s_ready stuck low");
    end
    s_ctx.addr = addr; s_ctx.burst = burst; s_ctx.size = size; s_ctx.len = len;
    s_ctx.id = id; s_ctx.user = user; s_ctx.lock = 1'b0;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("first_beat_valid", m_valid, 1);
    check("first_beat_idx", m_beat, 0);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_drain: %0d beats missing", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // m_ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_mode) m_ready = ~m_ready;
      else            m_ready = 1'b1;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    logic idle_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_chk = 1'b0;
        continue;
      end
      if (idle_chk) begin
        check("idle_s_ready", s_ready, 1);
        check("idle_m_valid", m_valid, 0);
        idle_chk = 1'b0;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_beat: addr 0x%0h beat %0d", m_addr, m_beat);
        end else begin
          e = exp_q[0];
          check(m_ready ? "beat_addr" : "stall_addr", m_addr, e.addr);
          check(m_ready ? "beat_idx"  : "stall_idx",  m_beat, e.beat);
          check("beat_id",   m_xfer.id,   e.id);
          check("beat_user", m_xfer.user, e.user);
          check("beat_resp", m_xfer.resp, e.resp);
          check("beat_last", m_xfer.last, e.last);
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (e.last) idle_chk = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp_4k;
    int guard;
`ifdef AXI_SEQ_4K_CHECK_EN
    resp_4k = ERR;
`else
    resp_4k = OK;
`endif
    // Reset values.
    #3;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_addr",  m_addr, 0);
    check("rst_m_beat",  m_beat, 0);
    check("rst_m_xfer",  m_xfer, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR unaligned start.
    push(32'h1002, 0, 4'h1, 4'h2, OK, 0);
    push(32'h1004, 1, 4'h1, 4'h2, OK, 0);
    push(32'h1008, 2, 4'h1, 4'h2, OK, 0);
    push(32'h100C, 3, 4'h1, 4'h2, OK, 1);
    send(32'h1002, AXI_BURST_INCR, 3'd2, 8'd3, 4'h1, 4'h2);
    drain("incr");

    // WRAP legal.
    push(32'h38, 0, 4'h3, 4'h4, OK, 0);
    push(32'h3C, 1, 4'h3, 4'h4, OK, 0);
    push(32'h30, 2, 4'h3, 4'h4, OK, 0);
    push(32'h34, 3, 4'h3, 4'h4, OK, 1);
    send(32'h38, AXI_BURST_WRAP, 3'd2, 8'd3, 4'h3, 4'h4);
    drain("wrap");

    // WRAP with len=2: SLVERR, walks as INCR.
    push(32'h38, 0, 4'h5, 4'h6, ERR, 0);
    push(32'h3C, 1, 4'h5, 4'h6, ERR, 0);
    push(32'h40, 2, 4'h5, 4'h6, ERR, 1);
    send(32'h38, AXI_BURST_WRAP, 3'd2, 8'd2, 4'h5, 4'h6);
    drain("wrap_len2");

    // WRAP misaligned: SLVERR, walks as INCR.
    push(32'h3A, 0, 4'h7, 4'h8, ERR, 0);
    push(32'h3C, 1, 4'h7, 4'h8, ERR, 0);
    push(32'h40, 2, 4'h7, 4'h8, ERR, 0);
    push(32'h44, 3, 4'h7, 4'h8, ERR, 1);
    send(32'h3A, AXI_BURST_WRAP, 3'd2, 8'd3, 4'h7, 4'h8);
    drain("wrap_misalign");

    // FIXED with m_ready toggling.
    for (int i = 0; i < 5; i++) push(32'h20, 8'(i), 4'hA, 4'h5, OK, i == 4);
    stall_mode = 1'b1;
    send(32'h20, AXI_BURST_FIXED, 3'd2, 8'd4, 4'hA, 4'h5);
    drain("fixed_stall");
    stall_mode = 1'b0;
    @(posedge clk); #1;

    // Oversize beat on a 32-bit bus.
    push(32'h100, 0, 4'h2, 4'h3, ERR, 0);
    push(32'h108, 1, 4'h2, 4'h3, ERR, 1);
    send(32'h100, AXI_BURST_INCR, 3'd3, 8'd1, 4'h2, 4'h3);
    drain("oversize");

    // Reserved burst type: SLVERR, walks as FIXED.
    push(32'h44, 0, 4'h9, 4'h1, ERR, 0);
    push(32'h44, 1, 4'h9, 4'h1, ERR, 0);
    push(32'h44, 2, 4'h9, 4'h1, ERR, 1);
    send(32'h44, AXI_BURST_RSVD, 3'd2, 8'd2, 4'h9, 4'h1);
    drain("reserved");

    // Reset asserted while beat 2 of an 8-beat INCR is presented.
    push(32'h200, 0, 4'hC, 4'hD, OK, 0);
    push(32'h204, 1, 4'hC, 4'hD, OK, 0);
    send(32'h200, AXI_BURST_INCR, 3'd2, 8'd7, 4'hC, 4'hD);
    guard = 0;
    while (!(m_valid && m_beat == 8'd2) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("mid_reached_beat2", m_beat, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_m_beat",  m_beat, 0);
    check("mid_rst_m_addr",  m_addr, 0);
    check("mid_rst_m_xfer",  m_xfer, 0);
    check("mid_rst_consumed", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_beats", m_valid, 0);

    // Next context after reset: single beat.
    push(32'h300, 0, 4'h4, 4'hE, OK, 1);
    send(32'h300, AXI_BURST_INCR, 3'd0, 8'd0, 4'h4, 4'hE);
    drain("single");

    // INCR crossing a 4KB page.
    push(32'hFF8,  0, 4'h6, 4'h7, resp_4k, 0);
    push(32'hFFC,  1, 4'h6, 4'h7, resp_4k, 0);
    push(32'h1000, 2, 4'h6, 4'h7, resp_4k, 0);
    push(32'h1004, 3, 4'h6, 4'h7, resp_4k, 1);
    send(32'hFF8, AXI_BURST_INCR, 3'd2, 8'd3, 4'h6, 4'h7);
    drain("cross4k");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
